// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding decode. Holds the fetch PC, issues in-order
//   word requests to instruction memory, keeps returned words together with
//   their PCs in a DEPTH-entry in-order queue and hands the queue head to
//   decode. A redirect (branch/jump/trap) reloads the fetch PC, flushes the
//   queue and arranges for the responses still in flight to be dropped.
//
//   Optional feature macro: FETCH_MISALIGN_EN
//     defined   : o_misaligned port exists; a redirect to a non word-aligned
//                 target parks the unit (no fetch, o_pc shows the bad target)
//                 until the next aligned redirect.
//     undefined : no o_misaligned port; redirect target bits [1:0] are ignored.
//
// Parameters
//   XLEN      PC/address width
//   RESET_PC  fetch PC after reset
//   DEPTH     queue entries (power of 2, >= 2); also bounds outstanding requests
//
// Ports
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_redirect,
//   i_redirect_pc          load a new fetch PC and flush (from execute)
//   o_imem_req,
//   o_imem_addr            request valid / word address (= fetch PC)
//   i_imem_gnt             request accepted this cycle
//   i_imem_rvalid,
//   i_imem_rdata           in-order response, latency >= 1
//   o_valid, o_instr, o_pc queue head offered to decode
//   i_ready                decode takes the head this cycle
//   o_misaligned           misaligned redirect target pending (macro only)
//
// Handshakes: a transfer happens in a cycle where valid (o_imem_req /
// o_valid) and its acceptance (i_imem_gnt / i_ready) are both high at the
// rising clock edge. valid never depends on the acceptance signal of the
// same interface, and the offered payload is stable while valid is high.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
`ifdef FETCH_MISALIGN_EN
    output logic            o_misaligned,
`endif
    input  logic            i_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Queue storage. An entry is allocated (PC written) at grant and becomes
    // visible to decode once its word has been filled.
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [AW-1:0]    head_ptr;   // oldest allocated entry
    logic [AW-1:0]    fill_ptr;   // oldest allocated entry still waiting for data
    logic [AW-1:0]    tail_ptr;   // next entry to allocate

    logic [CW-1:0]    alloc_cnt;   // allocated entries (filled or not)
    logic [CW-1:0]    pend_cnt;    // allocated entries still waiting for data
    logic [CW-1:0]    discard_cnt; // responses in flight that belong to a flushed stream

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  last_pc;     // values shown while the queue is empty
    logic [31:0]      last_instr;

    logic [XLEN-1:0]  redirect_target;
    logic             fetch_block;
    logic [CW:0]      credits_used;
    logic             head_filled;
    logic             do_alloc;
    logic             do_fill;
    logic             do_drop;
    logic             do_pop;
    logic [XLEN-1:0]  head_pc;

`ifdef FETCH_MISALIGN_EN
    logic             misaligned_q;
    logic [XLEN-1:0]  bad_pc_q;

    assign redirect_target = i_redirect_pc;
    assign fetch_block     = misaligned_q;
    assign o_misaligned    = misaligned_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misaligned_q <= 1'b0;
            bad_pc_q     <= '0;
        end else if (i_redirect) begin
            misaligned_q <= |i_redirect_pc[1:0];
            bad_pc_q     <= i_redirect_pc;
        end
    end
`else
    // Word fetch only: the low target bits are simply dropped.
    assign redirect_target = i_redirect_pc & ~XLEN'(3);
    assign fetch_block     = 1'b0;
`endif

    // Credits cover both live entries and responses we still owe a drop to,
    // so the memory can never return more words than there are slots.
    assign credits_used = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
    assign head_filled  = filled_q[head_ptr];

    assign o_imem_req  = i_rst_n && !i_redirect && !fetch_block &&
                         (credits_used < (CW+1)'(DEPTH));
    assign o_imem_addr = fetch_pc;
    assign o_valid     = head_filled && !i_redirect && !fetch_block;

    assign do_alloc = o_imem_req && i_imem_gnt;
    assign do_drop  = i_imem_rvalid && (discard_cnt != '0);
    assign do_fill  = i_imem_rvalid && (discard_cnt == '0) && !i_redirect;
    assign do_pop   = o_valid && i_ready;

    assign head_pc = head_filled ? pc_q[head_ptr] : last_pc;
    assign o_instr = head_filled ? instr_q[head_ptr] : last_instr;
`ifdef FETCH_MISALIGN_EN
    assign o_pc = misaligned_q ? bad_pc_q : head_pc;
`else
    assign o_pc = head_pc;
`endif

    // Payload storage needs no reset: it is only shown once its filled bit is set.
    always_ff @(posedge i_clk) begin
        if (do_alloc) begin
            pc_q[tail_ptr] <= fetch_pc;
        end
        if (do_fill) begin
            instr_q[fill_ptr] <= i_imem_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc    <= RESET_PC;
            filled_q    <= '0;
            head_ptr    <= '0;
            fill_ptr    <= '0;
            tail_ptr    <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            discard_cnt <= '0;
            last_pc     <= '0;
            last_instr  <= '0;
        end else if (i_redirect) begin
            // Every word still owed by memory now belongs to the dead stream.
            // A word arriving this very cycle is consumed here, hence the -1.
            fetch_pc    <= redirect_target;
            filled_q    <= '0;
            head_ptr    <= '0;
            fill_ptr    <= '0;
            tail_ptr    <= '0;
            alloc_cnt   <= '0;
            pend_cnt    <= '0;
            discard_cnt <= discard_cnt + pend_cnt - CW'(i_imem_rvalid);
        end else begin
            if (do_alloc) begin
                tail_ptr <= tail_ptr + PTR_ONE;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            // Fill and pop never touch the same entry: pop needs a filled
            // head, fill targets an unfilled one.
            if (do_fill) begin
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + PTR_ONE;
            end
            if (do_pop) begin
                filled_q[head_ptr] <= 1'b0;
                head_ptr           <= head_ptr + PTR_ONE;
                last_pc            <= pc_q[head_ptr];
                last_instr         <= instr_q[head_ptr];
            end
            if (do_drop) begin
                discard_cnt <= discard_cnt - CNT_ONE;
            end
            alloc_cnt <= alloc_cnt + CW'(do_alloc) - CW'(do_pop);
            pend_cnt  <= pend_cnt + CW'(do_alloc) - CW'(do_fill);
        end
    end

`ifndef SYNTHESIS
    // Memory must only answer requests it granted.
    rvalid_has_owner: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rvalid |-> ((discard_cnt != '0) || (pend_cnt != '0)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit (XLEN=32, RESET_PC=0x100, DEPTH=4). An instruction
//   memory model answers granted requests after a programmable latency with a
//   word derived from the address. A reference PC tracks every grant and every
//   redirect; expected PCs are queued at grant and compared at each pop.
//   A table covers the first cycles after reset; directed sequences cover
//   backpressure, redirects with words in flight, reset mid-burst and the
//   redirect-alignment behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h100;
    localparam int          DEPTH    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready = 1'b0;
`ifdef FETCH_MISALIGN_EN
    logic        misaligned;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_pc          (pc),
`ifdef FETCH_MISALIGN_EN
        .o_misaligned  (misaligned),
`endif
        .i_ready       (ready)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [31:0] a;
        int          cnt;
    } mreq_t;
    mreq_t mem_q[$];
    int    lat = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q.delete();
            rvalid = 1'b0;
            rdata  = '0;
        end else begin
            #1;
            rvalid = 1'b0;
            foreach (mem_q[i]) mem_q[i].cnt--;
            if (mem_q.size() > 0 && mem_q[0].cnt <= 0) begin
                rvalid = 1'b1;
                rdata  = instr_of(mem_q[0].a);
                void'(mem_q.pop_front());
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    int          gnt_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_pc = RESET_PC;
        end else begin
            if (req && gnt) begin
                check("grant_addr", addr, model_pc);
                exp_q.push_back(model_pc);
                mem_q.push_back('{a: addr, cnt: lat});
                model_pc = model_pc + 32'd4;
                gnt_seen++;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_pop: actual pc %h required no valid", pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("pop_pc", pc, e);
                    check("pop_instr", instr, instr_of(e));
                end
            end
            if (redirect) begin
                check("valid_in_redirect", {31'b0, valid}, 32'd0);
                check("req_in_redirect", {31'b0, req}, 32'd0);
                exp_q.delete();
`ifdef FETCH_MISALIGN_EN
                model_pc = redirect_pc;
`else
                model_pc = redirect_pc & ~32'h3;
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = target;
        next_cycle();
        redirect    = 1'b0;
    endtask

    // Called just after a drive point; waits for the next offered instruction.
    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!valid) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s_timeout: actual no valid in 40 cycles required pc %h", name, exp_pc);
        end else begin
            check({name, "_pc"}, pc, exp_pc);
            check({name, "_instr"}, instr, instr_of(exp_pc));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        gnt;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[11];

    initial begin
        // Cycle k after reset release, memory latency 1.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h10c, 1'b1, 32'h104};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10c};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h118, 1'b1, 32'h110};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h11c, 1'b1, 32'h110};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h120, 1'b1, 32'h110};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h120, 1'b1, 32'h110};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h120, 1'b1, 32'h114};

        // ---- reset state ----
        gnt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_addr", addr, RESET_PC);

        // ---- table: start-up, throughput, fill to full, release ----
        for (int k = 0; k < 11; k++) begin
            next_cycle();
            if (k == 0) rst_n = 1'b1;
            gnt   = tbl[k].gnt;
            ready = tbl[k].ready;
            @(negedge clk);
            check($sformatf("tbl%0d_req", k), {31'b0, req}, {31'b0, tbl[k].req});
            check($sformatf("tbl%0d_addr", k), addr, tbl[k].addr);
            check($sformatf("tbl%0d_valid", k), {31'b0, valid}, {31'b0, tbl[k].valid});
            if (tbl[k].valid) check($sformatf("tbl%0d_pc", k), pc, tbl[k].pc);
        end

        // ---- backpressure: exactly DEPTH grants, then in-order pops ----
        next_cycle();
        gnt = 1'b0;
        ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        next_cycle();
        gnt_seen = 0;
        gnt = 1'b1;
        repeat (8) next_cycle();
        @(negedge clk);
        check("full_grants", gnt_seen, DEPTH);
        check("full_req", {31'b0, req}, 32'd0);
        next_cycle();
        ready = 1'b1;
        @(negedge clk);
        check("drain_valid", {31'b0, valid}, 32'd1);
        check("drain_pc", pc, 32'h0);
        check("drain_req_hold", {31'b0, req}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("drain_req_resume", {31'b0, req}, 32'd1);
        check("drain_addr", addr, 32'h10);
        repeat (4) next_cycle();

        // ---- redirect with two requests in flight (latency 4) ----
        next_cycle();
        lat = 4;
        gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h500;
        next_cycle();
        redirect = 1'b0;
        gnt = 1'b1;
        next_cycle();
        next_cycle();
        gnt = 1'b0;
        next_cycle();
        gnt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        next_cycle();
        redirect = 1'b0;
        wait_valid("stale_drop", 32'h200);
        repeat (6) next_cycle();

        // ---- redirect colliding with rvalid and pop (latency 2) ----
        next_cycle();
        lat = 2;
        redirect = 1'b1;
        redirect_pc = 32'h700;
        next_cycle();
        redirect = 1'b0;
        repeat (10) next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h600;
        @(negedge clk);
        check("collide_rvalid_present", {31'b0, rvalid}, 32'd1);
        check("collide_valid", {31'b0, valid}, 32'd0);
        next_cycle();
        redirect = 1'b0;
        wait_valid("collide", 32'h600);

        // ---- reset mid-burst with a full queue ----
        next_cycle();
        lat = 1;
        ready = 1'b0;
        repeat (8) next_cycle();
        @(negedge clk);
        check("pre_rst_full_valid", {31'b0, valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'b0, req}, 32'd0);
        check("midrst_valid", {31'b0, valid}, 32'd0);
        check("midrst_pc", pc, 32'd0);
        check("midrst_instr", instr, 32'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        check("post_rst_req", {31'b0, req}, 32'd1);
        check("post_rst_addr", addr, RESET_PC);
        wait_valid("post_rst", RESET_PC);

        // ---- redirect alignment ----
`ifdef FETCH_MISALIGN_EN
        do_redirect(32'h202);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mis_flag", {31'b0, misaligned}, 32'd1);
            check("mis_req", {31'b0, req}, 32'd0);
            check("mis_valid", {31'b0, valid}, 32'd0);
            check("mis_pc", pc, 32'h202);
            next_cycle();
        end
        redirect = 1'b1;
        redirect_pc = 32'h300;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("mis_clear_flag", {31'b0, misaligned}, 32'd0);
        check("mis_clear_req", {31'b0, req}, 32'd1);
        check("mis_clear_addr", addr, 32'h300);
        next_cycle();
        wait_valid("realign", 32'h300);
`else
        do_redirect(32'h202);
        @(negedge clk);
        check("align_req", {31'b0, req}, 32'd1);
        check("align_addr", addr, 32'h200);
        next_cycle();
        wait_valid("align", 32'h200);
`endif

        repeat (6) next_cycle();
        gnt = 1'b0;
        repeat (4) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: actual still running required finished");
        err_cnt++;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $fatal(1, "timeout");
    end

endmodule
